// File: rtl/bcd3_count_ctrl.sv
// rtl/bcd3_count_ctrl.sv - run-control sequencer for a 3-digit BCD event counter
module bcd3_count_ctrl #(
  parameter bit AUTO_RELOAD = 1'b0,
  parameter bit WRAP_EN     = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_start,
  input  logic        cmd_stop,
  input  logic        cmd_clear,
  input  logic        tick,
  input  logic [11:0] load_val,
  input  logic [11:0] target,
  output logic [11:0] count,
  output logic [1:0]  state,
  output logic        busy,
  output logic        done,
  output logic        wrap,
  output logic        err
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_PAUSE = 2'b10;
  localparam logic [1:0] ST_DONE  = 2'b11;

  localparam logic [11:0] BCD_MAX = 12'h999;

  logic [1:0]  state_q, state_d;
  logic [11:0] count_q, count_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic        wrap_q, wrap_d;
  logic        err_q, err_d;

  logic [11:0] count_inc;
  logic        at_max;
  logic        load_ok;

  // every nibble of a BCD word must be a decimal digit
  function automatic logic bcd_valid(input logic [11:0] v);
    return (v[3:0] <= 4'd9) && (v[7:4] <= 4'd9) && (v[11:8] <= 4'd9);
  endfunction

  // decimal +1 with the whole carry chain resolved in one step; 999 -> 000
  function automatic logic [11:0] bcd_inc(input logic [11:0] v);
    logic [3:0] u, t, h;
    u = v[3:0];
    t = v[7:4];
    h = v[11:8];
    if (u == 4'd9) begin
      u = 4'd0;
      if (t == 4'd9) begin
        t = 4'd0;
        h = (h == 4'd9) ? 4'd0 : h + 4'd1;
      end else begin
        t = t + 4'd1;
      end
    end else begin
      u = u + 4'd1;
    end
    return {h, t, u};
  endfunction

  assign count_inc = bcd_inc(count_q);
  assign at_max    = (count_q == BCD_MAX);
  assign load_ok   = bcd_valid(load_val) && bcd_valid(target);

  // next-state: command priority is clear > stop > start > tick
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    done_d  = 1'b0;
    wrap_d  = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_clear) begin
          count_d = 12'h000;
        end else if (cmd_stop) begin
          state_d = ST_IDLE;
        end else if (cmd_start) begin
          if (load_ok) begin
            count_d = load_val;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (cmd_clear) begin
          count_d = 12'h000;
          state_d = ST_IDLE;
        end else if (cmd_stop) begin
          state_d = ST_PAUSE;
        end else if (tick) begin
          // saturating mode at 999: no increment, so no compare either
          if (!(at_max && !WRAP_EN)) begin
            count_d = count_inc;
            wrap_d  = at_max;
            if (count_inc == target) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
      end
      ST_PAUSE: begin
        if (cmd_clear) begin
          count_d = 12'h000;
          state_d = ST_IDLE;
        end else if (cmd_stop) begin
          state_d = ST_PAUSE;
        end else if (cmd_start) begin
          // resume without reload, so the presets are not re-checked
          state_d = ST_RUN;
        end
      end
      default: begin
        if (cmd_clear) begin
          count_d = 12'h000;
          state_d = ST_IDLE;
        end else if (AUTO_RELOAD) begin
          // reload cycle: any tick arriving now is intentionally dropped
          count_d = load_val;
          state_d = ST_RUN;
        end else if (cmd_stop) begin
          state_d = ST_DONE;
        end else if (cmd_start) begin
          if (load_ok) begin
            count_d = load_val;
            state_d = ST_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
    endcase
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
  end

  // state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count_q <= 12'h000;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wrap_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      wrap_q  <= wrap_d;
      err_q   <= err_d;
    end
  end

  assign count = count_q;
  assign state = state_q;
  assign busy  = busy_q;
  assign done  = done_q;
  assign wrap  = wrap_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd3_count_ctrl.sv
// tb/tb_bcd3_count_ctrl.sv - directed self-checking bench for bcd3_count_ctrl
module tb_bcd3_count_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_start, cmd_stop, cmd_clear, tick;
  logic [11:0] load_val, target;

  // dut0: hold in DONE, wrap; dut1: saturate; dut2: auto reload, wrap
  logic [11:0] c0, c1, c2;
  logic [1:0]  s0, s1, s2;
  logic        b0, b1, b2, d0, d1, d2, w0, w1, w2, e0, e1, e2;

  int n_checks = 0;
  int n_errors = 0;

  logic [11:0] seq2 [6] = '{12'h096, 12'h097, 12'h098, 12'h099, 12'h100, 12'h101};
  logic [11:0] seq3 [7] = '{12'h999, 12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005};
  logic [11:0] seq6 [5] = '{12'h011, 12'h012, 12'h010, 12'h011, 12'h012};
  logic [1:0]  st6  [5] = '{2'b01, 2'b11, 2'b01, 2'b01, 2'b11};

  always #5 clk = ~clk;

  bcd3_count_ctrl #(.AUTO_RELOAD(1'b0), .WRAP_EN(1'b1)) dut0 (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_clear(cmd_clear), .tick(tick), .load_val(load_val), .target(target),
    .count(c0), .state(s0), .busy(b0), .done(d0), .wrap(w0), .err(e0));

  bcd3_count_ctrl #(.AUTO_RELOAD(1'b0), .WRAP_EN(1'b0)) dut1 (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_clear(cmd_clear), .tick(tick), .load_val(load_val), .target(target),
    .count(c1), .state(s1), .busy(b1), .done(d1), .wrap(w1), .err(e1));

  bcd3_count_ctrl #(.AUTO_RELOAD(1'b1), .WRAP_EN(1'b1)) dut2 (
    .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_stop(cmd_stop),
    .cmd_clear(cmd_clear), .tick(tick), .load_val(load_val), .target(target),
    .count(c2), .state(s2), .busy(b2), .done(d2), .wrap(w2), .err(e2));

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_all();
    cmd_clear = 1'b1;
    tick = 1'b0;
    cyc();
    cmd_clear = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    cmd_start = 1'b0; cmd_stop = 1'b0; cmd_clear = 1'b0; tick = 1'b1;
    load_val = 12'h000; target = 12'h000;

    // reset with tick high and no start
    repeat (3) cyc();
    check("rst_count", c0, 12'h000);
    check("rst_state", {10'd0, s0}, 12'h000);
    check("rst_flags", {8'd0, b0, d0, w0, e0}, 12'h000);
    reset = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      check("idle_count", c0, 12'h000);
      check("idle_state", {10'd0, s0}, 12'h000);
      check("idle_busy", {11'd0, b0}, 12'h000);
    end

    // 095 -> 101 with carries through tens and hundreds
    tick = 1'b0; load_val = 12'h095; target = 12'h101; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    check("t2_load", c0, 12'h095);
    check("t2_state", {10'd0, s0}, 12'h001);
    check("t2_busy", {11'd0, b0}, 12'h001);
    tick = 1'b1;
    for (int i = 0; i < 6; i++) begin
      cyc();
      check("t2_count", c0, seq2[i]);
      check("t2_done", {11'd0, d0}, (i == 5) ? 12'h001 : 12'h000);
    end
    check("t2_state_done", {10'd0, s0}, 12'h003);
    check("t2_busy_done", {11'd0, b0}, 12'h000);
    tick = 1'b0;
    cyc();
    check("t2_done_pulse", {11'd0, d0}, 12'h000);
    check("t2_hold", c0, 12'h101);
    check("t2_ar_reload", c2, 12'h095);
    check("t2_ar_state", {10'd0, s2}, 12'h001);
    clear_all();
    check("t2_clr_count", c0, 12'h000);
    check("t2_clr_state", {10'd0, s0}, 12'h000);

    // rollover past 999, wrapping and saturating variants
    load_val = 12'h998; target = 12'h005; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    check("t3_load", c0, 12'h998);
    tick = 1'b1;
    for (int i = 0; i < 7; i++) begin
      cyc();
      check("t3_count", c0, seq3[i]);
      check("t3_wrap", {11'd0, w0}, (i == 1) ? 12'h001 : 12'h000);
      check("t3_done", {11'd0, d0}, (i == 6) ? 12'h001 : 12'h000);
      check("t3_sat_count", c1, 12'h999);
      check("t3_sat_flags", {10'd0, w1, d1}, 12'h000);
    end
    check("t3_state", {10'd0, s0}, 12'h003);
    check("t3_sat_state", {10'd0, s1}, 12'h001);
    clear_all();

    // pause drops the coincident tick and holds the count
    load_val = 12'h040; target = 12'h999; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0; tick = 1'b1;
    cyc(); cyc();
    check("t4_count", c0, 12'h042);
    cmd_stop = 1'b1;
    cyc();
    cmd_stop = 1'b0;
    check("t4_pause_state", {10'd0, s0}, 12'h002);
    check("t4_pause_count", c0, 12'h042);
    check("t4_pause_busy", {11'd0, b0}, 12'h001);
    repeat (3) cyc();
    check("t4_hold", c0, 12'h042);
    tick = 1'b0; load_val = 12'h0AA; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    check("t4_resume_state", {10'd0, s0}, 12'h001);
    check("t4_resume_count", c0, 12'h042);
    check("t4_resume_err", {11'd0, e0}, 12'h000);
    tick = 1'b1;
    cyc();
    check("t4_inc", c0, 12'h043);
    clear_all();

    // invalid presets are rejected with a single err pulse
    load_val = 12'h0A3; target = 12'h101; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    check("t5_err", {11'd0, e0}, 12'h001);
    check("t5_state", {10'd0, s0}, 12'h000);
    check("t5_count", c0, 12'h000);
    cyc();
    check("t5_err_pulse", {11'd0, e0}, 12'h000);
    load_val = 12'h001; target = 12'h10A; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    check("t5_err_tgt", {11'd0, e0}, 12'h001);
    check("t5_state_tgt", {10'd0, s0}, 12'h000);

    // auto reload with continuous tick
    load_val = 12'h010; target = 12'h012; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    check("t6_load", c2, 12'h010);
    tick = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t6_count", c2, seq6[i]);
      check("t6_state", {10'd0, s2}, {10'd0, st6[i]});
      check("t6_done", {11'd0, d2}, (st6[i] == 2'b11) ? 12'h001 : 12'h000);
    end
    cmd_clear = 1'b1;
    cyc();
    cmd_clear = 1'b0;
    check("t6_clr_count", c2, 12'h000);
    check("t6_clr_state", {10'd0, s2}, 12'h000);

    // asynchronous reset mid-run takes effect before the next edge
    target = 12'h050; cmd_start = 1'b1;
    cyc();
    cmd_start = 1'b0;
    cyc(); cyc();
    check("t7_pre", c2, 12'h012);
    #2;
    reset = 1'b0;
    #1;
    check("t7_async_count", c2, 12'h000);
    check("t7_async_state", {10'd0, s2}, 12'h000);
    check("t7_async_flags", {8'd0, b2, d2, w2, e2}, 12'h000);
    cyc();
    check("t7_held", c2, 12'h000);
    reset = 1'b1;
    tick = 1'b0;
    cyc();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
